// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 keypad scanner.
//   kp_state_t - scanner FSM states
//   row_hit_t  - result of decoding a row pattern (valid + row index)
//   KEY_MAP    - hex code for each key, indexed by {column, row}
//   one_low()  - decodes a row pattern with exactly one low bit
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } kp_state_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] ri;
    } row_hit_t;

    // Rows run down each column: index = {ci, ri}.
    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h4, 4'h7, 4'h0,
        4'h2, 4'h5, 4'h8, 4'hF,
        4'h3, 4'h6, 4'h9, 4'hE,
        4'hA, 4'hB, 4'hC, 4'hD
    };

    // Only a single low row is a key; none or several low rows decode as no key.
    function automatic row_hit_t one_low(input logic [3:0] rows);
        row_hit_t hit;
        hit.valid = 1'b0;
        hit.ri    = 2'd0;
        case (rows)
            4'b1110: begin hit.valid = 1'b1; hit.ri = 2'd0; end
            4'b1101: begin hit.valid = 1'b1; hit.ri = 2'd1; end
            4'b1011: begin hit.valid = 1'b1; hit.ri = 2'd2; end
            4'b0111: begin hit.valid = 1'b1; hit.ri = 2'd3; end
            default: begin hit.valid = 1'b0; hit.ri = 2'd0; end
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// keypad_row_sync: two-flop synchronizer for the active-low keypad rows.
//   clk    in  system clock
//   rst    in  synchronous active-high reset (rows read as released)
//   row_in in  raw rows, asynchronous to clk
//   rows   out synchronized rows, two cycles behind row_in
module keypad_row_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] rows
);

    logic [3:0] meta_q;
    logic [3:0] rows_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 4'b1111;
            rows_q <= 4'b1111;
        end else begin
            meta_q <= row_in;
            rows_q <= meta_q;
        end
    end

    assign rows = rows_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: column scanner, press/release debouncer and key encoder
// for a 4x4 active-low keypad.
//   clk         in  system clock
//   rst         in  synchronous active-high reset
//   row_in      in  raw keypad rows (active-low, asynchronous)
//   col_out     out one-cold column drive
//   key_code    out hex code of the last accepted key
//   key_valid   out one-cycle strobe per accepted key
//   key_pressed out high from acceptance until the release has debounced
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int clk_freq      = 125_000_000,
    parameter int col_period_us = 1,
    parameter int stable_time   = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_pressed
);

    localparam int COL_CYCLES = clk_freq / 1_000_000 * col_period_us;
    localparam int DB_CYCLES  = clk_freq / 1000 * stable_time;
    localparam int CNT_MAX    = (DB_CYCLES > COL_CYCLES) ? DB_CYCLES : COL_CYCLES;
    localparam int CNT_W      = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(COL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DB_CYCLES - 1);

    logic [3:0] rows;

    keypad_row_sync u_row_sync (
        .clk    (clk),
        .rst    (rst),
        .row_in (row_in),
        .rows   (rows)
    );

    kp_state_t        state_q,       state_d;
    logic [1:0]       ci_q,          ci_d;
    logic [CNT_W-1:0] cnt_q,         cnt_d;
    logic [3:0]       cap_q,         cap_d;
    logic [3:0]       cap_code_q,    cap_code_d;
    logic [3:0]       col_out_q,     col_out_d;
    logic [3:0]       key_code_q,    key_code_d;
    logic             key_valid_q,   key_valid_d;
    logic             key_pressed_q, key_pressed_d;
    row_hit_t         sample;

    always_comb begin
        state_d       = state_q;
        ci_d          = ci_q;
        cnt_d         = cnt_q;
        cap_d         = cap_q;
        cap_code_d    = cap_code_q;
        key_code_d    = key_code_q;
        key_valid_d   = 1'b0;
        key_pressed_d = key_pressed_q;
        sample        = one_low(rows);

        case (state_q)
            SCAN: begin
                if (cnt_q == COL_LAST) begin
                    cnt_d = '0;
                    if (sample.valid) begin
                        // Code is resolved now so the column index only has
                        // to be held, not re-decoded, at acceptance time.
                        cap_d      = rows;
                        cap_code_d = KEY_MAP[{ci_q, sample.ri}];
                        state_d    = DEBOUNCE;
                    end else begin
                        ci_d = ci_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (rows != cap_q) begin
                    cnt_d   = '0;
                    ci_d    = ci_q + 2'd1;
                    state_d = SCAN;
                end else if (cnt_q == DB_LAST) begin
                    cnt_d         = '0;
                    key_code_d    = cap_code_q;
                    key_valid_d   = 1'b1;
                    key_pressed_d = 1'b1;
                    state_d       = HELD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                // Extra keys while held are ignored; only all-released counts.
                cnt_d = '0;
                if (rows == 4'b1111) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (rows != 4'b1111) begin
                    cnt_d   = '0;
                    state_d = HELD;
                end else if (cnt_q == DB_LAST) begin
                    cnt_d         = '0;
                    key_pressed_d = 1'b0;
                    ci_d          = ci_q + 2'd1;
                    state_d       = SCAN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = SCAN;
            end
        endcase

        // Column drive is registered from the next index so it tracks ci_q.
        col_out_d = ~(4'b0001 << ci_d);
    end

    always_ff @(posedge clk) begin
        cap_q      <= cap_d;
        cap_code_q <= cap_code_d;
        if (rst) begin
            state_q       <= SCAN;
            ci_q          <= 2'd0;
            cnt_q         <= '0;
            col_out_q     <= 4'b1110;
            key_code_q    <= 4'h0;
            key_valid_q   <= 1'b0;
            key_pressed_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ci_q          <= ci_d;
            cnt_q         <= cnt_d;
            col_out_q     <= col_out_d;
            key_code_q    <= key_code_d;
            key_valid_q   <= key_valid_d;
            key_pressed_q <= key_pressed_d;
        end
    end

    assign col_out     = col_out_q;
    assign key_code    = key_code_q;
    assign key_valid   = key_valid_q;
    assign key_pressed = key_pressed_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: self-checking bench for keypad_scanner with a
// behavioural keypad (key matrix driven by col_out) and a code model.
module tb_keypad_scanner;

    localparam int COL_CYCLES = 4;
    localparam int DB_CYCLES  = 1000;
    localparam int MAX_LAT    = 4 * COL_CYCLES + DB_CYCLES + 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_pressed;

    // Physical keys currently held down, index = column*4 + row.
    logic [15:0] keys = '0;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int strobes  = 0;
    int code_bad = 0;
    int pv_bad   = 0;
    logic [3:0] prev_code    = 4'h0;
    logic       prev_pressed = 1'b0;
    logic       rst_edge     = 1'b1;

    keypad_scanner #(
        .clk_freq      (1_000_000),
        .col_period_us (4),
        .stable_time   (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .row_in      (row_in),
        .col_out     (col_out),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_pressed (key_pressed)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a row reads low when a held key sits in a driven column.
    always_comb begin
        row_in = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (keys[c*4+r] && !col_out[c]) row_in[r] = 1'b0;
    end

    always @(posedge clk) begin
        cyc++;
        rst_edge = rst;
    end

    always @(negedge clk) begin
        if (key_valid) begin
            strobes++;
            if (!key_pressed || prev_pressed) pv_bad++;
        end
        if (!key_valid && !rst_edge && key_code !== prev_code) code_bad++;
        prev_code    = key_code;
        prev_pressed = key_pressed;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Keypad legend: columns 0..2 hold the 3x3 digit block plus 0/F/E on the
    // bottom row; column 3 holds A..D.
    function automatic int model_code(input int r, input int c);
        if (c == 3) return 10 + r;
        if (r < 3)  return 3 * r + c + 1;
        if (c == 0) return 0;
        if (c == 1) return 15;
        return 14;
    endfunction

    task automatic wait_strobe(input int budget, output bit got, output int lat,
                               output logic [3:0] code);
        int start;
        start = cyc;
        got   = 1'b0;
        lat   = 0;
        code  = 4'h0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (key_valid) begin
                got  = 1'b1;
                lat  = cyc - start;
                code = key_code;
                break;
            end
        end
    endtask

    task automatic press_release(input string tag, input int r, input int c, input int hold);
        bit got;
        int lat;
        logic [3:0] code;
        int s0;
        s0 = strobes;
        keys[c*4+r] = 1'b1;
        wait_strobe(MAX_LAT + 50, got, lat, code);
        check_eq({tag, "_strobe"}, int'(got), 1);
        check_eq({tag, "_code"}, int'(code), model_code(r, c));
        check_eq({tag, "_latency_ok"}, int'(lat >= DB_CYCLES && lat <= MAX_LAT), 1);
        repeat (hold) @(negedge clk);
        check_eq({tag, "_held_pressed"}, int'(key_pressed), 1);
        keys[c*4+r] = 1'b0;
        repeat (DB_CYCLES - 10) @(negedge clk);
        check_eq({tag, "_release_pressed_hi"}, int'(key_pressed), 1);
        repeat (20) @(negedge clk);
        check_eq({tag, "_release_pressed_lo"}, int'(key_pressed), 0);
        check_eq({tag, "_one_strobe"}, strobes - s0, 1);
        check_eq({tag, "_code_kept"}, int'(key_code), model_code(r, c));
    endtask

    initial begin
        bit got;
        int lat;
        logic [3:0] code;
        int s0;
        int k;
        int n;
        int bad;
        int changes;
        int lows;
        logic [3:0] prev_col;

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_col_out", int'(col_out), 4'b1110);
        check_eq("rst_key_code", int'(key_code), 0);
        check_eq("rst_key_valid", int'(key_valid), 0);
        check_eq("rst_key_pressed", int'(key_pressed), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Key 5 held for about 3000 cycles
        press_release("key5", 1, 1, 2000);

        // Key 9 bouncing with sub-debounce intervals
        s0 = strobes;
        k = 0;
        keys[2*4+2] = 1'b1;
        while (k < 2000) begin
            n = $urandom_range(50, 900);
            repeat (n) @(negedge clk);
            k += n;
            keys[2*4+2] = ~keys[2*4+2];
        end
        keys[2*4+2] = 1'b0;
        check_eq("bounce_no_strobe", strobes - s0, 0);
        check_eq("bounce_not_pressed", int'(key_pressed), 0);
        repeat (10) @(negedge clk);
        prev_col = col_out;
        bad = 0;
        changes = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (col_out != prev_col) begin
                changes++;
                if (col_out != {prev_col[2:0], prev_col[3]}) bad++;
            end
            prev_col = col_out;
        end
        check_eq("col_rotation_order", bad, 0);
        check_eq("col_rotation_moves", int'(changes >= 8), 1);

        // Keys 1 and 4 together, then 4 released
        s0 = strobes;
        keys[0] = 1'b1;
        keys[1] = 1'b1;
        repeat (2500) @(negedge clk);
        check_eq("two_keys_no_strobe", strobes - s0, 0);
        check_eq("two_keys_not_pressed", int'(key_pressed), 0);
        keys[1] = 1'b0;
        wait_strobe(MAX_LAT + 50, got, lat, code);
        check_eq("single_after_two_strobe", int'(got), 1);
        check_eq("single_after_two_code", int'(code), model_code(0, 0));
        check_eq("single_after_two_latency", int'(lat <= MAX_LAT), 1);
        keys[0] = 1'b0;
        repeat (DB_CYCLES + 100) @(negedge clk);
        check_eq("single_after_two_released", int'(key_pressed), 0);

        // D then 0
        press_release("keyD", 3, 3, $urandom_range(200, 1500));
        press_release("key0", 3, 0, $urandom_range(200, 1500));

        // Reset while key 3 is held
        keys[2*4+0] = 1'b1;
        wait_strobe(MAX_LAT + 50, got, lat, code);
        check_eq("key3_strobe", int'(got), 1);
        check_eq("key3_code", int'(code), model_code(0, 2));
        repeat ($urandom_range(10, 500)) @(negedge clk);
        check_eq("key3_pressed_before_rst", int'(key_pressed), 1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("midheld_rst_pressed", int'(key_pressed), 0);
        check_eq("midheld_rst_code", int'(key_code), 0);
        check_eq("midheld_rst_col", int'(col_out), 4'b1110);
        rst = 1'b0;
        wait_strobe(MAX_LAT + 50, got, lat, code);
        check_eq("key3_restrobe", int'(got), 1);
        check_eq("key3_restrobe_code", int'(code), model_code(0, 2));
        check_eq("key3_restrobe_latency", int'(lat >= DB_CYCLES && lat <= MAX_LAT), 1);
        keys[2*4+0] = 1'b0;
        repeat (DB_CYCLES + 100) @(negedge clk);
        check_eq("key3_released", int'(key_pressed), 0);

        // Release glitch while E is held
        s0 = strobes;
        keys[2*4+3] = 1'b1;
        wait_strobe(MAX_LAT + 50, got, lat, code);
        check_eq("keyE_strobe", int'(got), 1);
        check_eq("keyE_code", int'(code), model_code(3, 2));
        repeat (300) @(negedge clk);
        keys[2*4+3] = 1'b0;
        n = $urandom_range(50, 900);
        lows = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (!key_pressed) lows++;
        end
        keys[2*4+3] = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!key_pressed) lows++;
        end
        check_eq("keyE_glitch_pressed_drops", lows, 0);
        repeat (500) @(negedge clk);
        keys[2*4+3] = 1'b0;
        repeat (DB_CYCLES + 100) @(negedge clk);
        check_eq("keyE_one_strobe", strobes - s0, 1);
        check_eq("keyE_released", int'(key_pressed), 0);

        // Random keys with random hold lengths
        for (int t = 0; t < 6; t++) begin
            press_release($sformatf("rnd%0d", t), $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(100, 1500));
        end

        check_eq("key_code_only_moves_on_strobe", code_bad, 0);
        check_eq("valid_rises_with_pressed", pv_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
